// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and timer sizing.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Timer must hold the larger of the two phase lengths minus one, plus headroom for the load value.
  function automatic int timer_width(input int on_cycles, input int gap_cycles);
    int longest;
    longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a zero flag; parks at zero instead of wrapping.
module pulse_timer
  import pulse_stretch_pkg::*;
#(
  parameter int W = timer_width(16, 8)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: flops use non-blocking assignments and an async reset in the sensitivity list,
  // so clr clears the count immediately rather than at the next edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Turns single-cycle events into ON_CYCLES-wide pulses separated by GAP_CYCLES of low time,
// queueing overlapping events. Define PULSE_STRETCH_OVF_EN to get the sticky ovf drop flag.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int ON_CYCLES  = 16,
  parameter int GAP_CYCLES = 8,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              trig,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending
`ifdef PULSE_STRETCH_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int              TW       = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t        state;
  state_t        state_next;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic [TW-1:0] timer_count;
  logic          timer_zero;
  logic          take_pend;
  logic          take_trig;
  logic          inc;

  pulse_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (timer_load),
    .load_val (timer_val),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = ON_LOAD;
    take_pend  = 1'b0;
    take_trig  = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) begin
          state_next = ON;
          timer_load = 1'b1;
          take_trig  = 1'b1;
        end
      end
      ON: begin
        if (timer_zero) begin
          state_next = GAP;
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end
      end
      GAP: begin
        if (timer_zero) begin
          // Queued events are older than the current trig, so they are replayed first.
          if (pending != '0) begin
            state_next = ON;
            timer_load = 1'b1;
            take_pend  = 1'b1;
          end else if (trig) begin
            state_next = ON;
            timer_load = 1'b1;
            take_trig  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out  = (state == ON);
    busy = (state != IDLE);
  end

  assign inc = trig & ~take_trig;

  // A simultaneous increment and decrement cancel, which also covers the saturated case.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending <= '0;
    end else if (inc && !take_pend && pending != PEND_MAX) begin
      pending <= pending + 1'b1;
    end else if (take_pend && !inc) begin
      pending <= pending - 1'b1;
    end
  end

`ifdef PULSE_STRETCH_OVF_EN
  logic drop;

  assign drop = inc & ~take_pend & (pending == PEND_MAX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: time-scheduled reference model plus pinned literal values.
module tb_pulse_stretch;

  localparam int ON_C = 4;
  localparam int GAP_C = 2;
  localparam int PW = 2;
  localparam int MAXP = 3;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          trig = 1'b0;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
`ifdef PULSE_STRETCH_OVF_EN
  logic          ovf;
`endif

  always #5 clk = ~clk;

  pulse_stretch #(
    .ON_CYCLES  (ON_C),
    .GAP_CYCLES (GAP_C),
    .PEND_W     (PW)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .trig    (trig),
    .out     (out),
    .busy    (busy),
    .pending (pending)
`ifdef PULSE_STRETCH_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model thinks in absolute cycle numbers: each started pulse reserves the window
  // [start, start+ON+GAP); queued events wait for the window to expire.
  typedef struct {
    int o;
    int free_at;
    int last_start;
    bit have;
    bit ovf;
    bit out;
    bit busy;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '{o: 0, free_at: 0, last_start: 0, have: 1'b0, ovf: 1'b0, out: 1'b0, busy: 1'b0};
    return r;
  endfunction

  function automatic model_t model_step(input model_t cur, input logic t, input int n);
    model_t r;
    int     tot;
    r   = cur;
    tot = cur.o + (t ? 1 : 0);
    if (tot > 0 && n >= cur.free_at) begin
      r.last_start = n;
      r.have       = 1'b1;
      r.free_at    = n + ON_C + GAP_C;
      tot          = tot - 1;
    end
    if (tot > MAXP) begin
      tot   = MAXP;
      r.ovf = 1'b1;
    end
    r.o    = tot;
    r.out  = r.have && (n >= r.last_start) && (n < r.last_start + ON_C);
    r.busy = (n < r.free_at);
    return r;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) m <= model_reset();
    else     m <= model_step(m, trig, cyc + 1);
  end

  // Pinned literal expectations: sig 0=out 1=busy 2=pending 3=ovf 4=rising edges seen.
  typedef struct {
    int c;
    int sig;
    int val;
  } pin_t;

  pin_t  pins[$];
  int    base = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    rises = 0;
  logic  prev_out = 1'b0;
  string sig_name[5] = '{"out", "busy", "pending", "ovf", "rises"};

  function automatic void pin(input int c, input int sig, input int val);
    pins.push_back('{c: c, sig: sig, val: val});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (rel cycle %0d, t=%0t)", name, act, exp, cyc - base, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge clr);
      if (clk) begin
        // clr edge mid-cycle: outputs must drop before any clock edge
        #1;
        check("clr_async_out", out, 0);
        check("clr_async_busy", busy, 0);
        check("clr_async_pending", pending, 0);
`ifdef PULSE_STRETCH_OVF_EN
        check("clr_async_ovf", ovf, 0);
`endif
        rises    = 0;
        prev_out = 1'b0;
      end else begin
        check("model_out", out, m.out);
        check("model_busy", busy, m.busy);
        check("model_pending", pending, m.o);
`ifdef PULSE_STRETCH_OVF_EN
        check("model_ovf", ovf, m.ovf);
`endif
        if (clr) begin
          rises    = 0;
          prev_out = 1'b0;
        end else begin
          if (out && !prev_out) rises++;
          prev_out = out;
          foreach (pins[i]) begin
            if (pins[i].c == cyc - base) begin
              int act;
              case (pins[i].sig)
                0:       act = out;
                1:       act = busy;
                2:       act = pending;
`ifdef PULSE_STRETCH_OVF_EN
                3:       act = ovf;
`endif
                default: act = rises;
              endcase
              check($sformatf("pin_%s@%0d", sig_name[pins[i].sig], pins[i].c), act, pins[i].val);
            end
          end
        end
      end
    end
  end

  task automatic at_cycle(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    pins.delete();
    trig = 1'b0;
    clr  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clr  = 1'b0;
    base = cyc;
  endtask

  task automatic trig_at(input int k);
    at_cycle(k);
    trig = 1'b1;
    at_cycle(k + 1);
    trig = 1'b0;
  endtask

  initial begin
    // 1: single event
    do_reset();
    pin(10, 0, 0); pin(11, 0, 1); pin(14, 0, 1); pin(15, 0, 0);
    pin(11, 1, 1); pin(16, 1, 1); pin(17, 1, 0); pin(12, 2, 0); pin(20, 4, 1);
    trig_at(10);
    at_cycle(30);

    // 2: overlapping events replayed in order
    do_reset();
    pin(11, 0, 1); pin(15, 0, 0); pin(17, 0, 1); pin(22, 0, 0); pin(23, 0, 1);
    pin(13, 2, 1); pin(14, 2, 2); pin(17, 2, 1); pin(22, 2, 1); pin(23, 2, 0);
    pin(30, 4, 3);
    trig_at(10);
    trig_at(12);
    trig_at(13);
    at_cycle(35);

    // 3: trig held 5 cycles, queue saturates and one event drops
    do_reset();
    pin(14, 2, 3); pin(15, 2, 3); pin(40, 4, 4); pin(40, 0, 0); pin(40, 1, 0);
`ifdef PULSE_STRETCH_OVF_EN
    pin(14, 3, 0); pin(15, 3, 1); pin(40, 3, 1);
`endif
    at_cycle(10);
    trig = 1'b1;
    at_cycle(15);
    trig = 1'b0;
    at_cycle(45);

    // 4: trig in last gap cycle with empty queue restarts with no idle cycle
    do_reset();
    pin(16, 0, 0); pin(16, 2, 0); pin(17, 0, 1); pin(17, 1, 1); pin(17, 2, 0);
    pin(20, 0, 1); pin(21, 0, 0); pin(30, 4, 2);
    trig_at(10);
    trig_at(16);
    at_cycle(35);

    // 5: full queue at gap end with coincident trig: no drop
    do_reset();
    pin(14, 2, 3); pin(16, 2, 3); pin(17, 2, 3); pin(17, 0, 1); pin(45, 4, 5); pin(45, 2, 0);
`ifdef PULSE_STRETCH_OVF_EN
    pin(17, 3, 0); pin(45, 3, 0);
`endif
    at_cycle(10);
    trig = 1'b1;
    at_cycle(14);
    trig = 1'b0;
    trig_at(16);
    at_cycle(50);

    // 6: asynchronous clear mid-pulse, then a normal pulse after release
    do_reset();
    pin(11, 0, 1); pin(20, 0, 0); pin(21, 0, 1); pin(24, 0, 1); pin(25, 0, 0);
    pin(22, 2, 0); pin(26, 1, 1); pin(27, 1, 0); pin(30, 4, 1);
    trig_at(10);
    at_cycle(12);
    #1;
    clr = 1'b1;
    at_cycle(14);
    clr = 1'b0;
    trig_at(20);
    at_cycle(35);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
Output-side counterpart to the button input path. It takes single-cycle event pulses, such as debounced button edges or game events, and drives them onto a slow physical indicator: an LED or a buzzer enable. Each accepted event becomes one output pulse of ON_CYCLES, followed by a mandatory low gap of GAP_CYCLES. Events that arrive while a pulse or gap is in progress are queued in a saturating pending counter and are replayed in order, so none are lost up to the queue depth.

Parameters:
ON_CYCLES, 16, output-high duration per event in clk cycles; must be >= 1
GAP_CYCLES, 8, forced low time after each pulse in clk cycles; must be >= 1
PEND_W, 3, pending-counter width; queue depth is 2^PEND_W-1

Ports:
clk  input  1  clock
clr  input  1  reset, asynchronous, active-high
trig  input  1  event request, sampled every posedge clk; each high cycle is one event
out  output  1  stretched pulse to the indicator
busy  output  1  high whenever state is not IDLE
pending  output  PEND_W  number of queued, not-yet-started events
ovf  output  1  sticky drop flag; present only with PULSE_STRETCH_OVF_EN

Behaviour:
- Reset (clr high, asynchronous): state=IDLE, out=0, busy=0, pending=0, timer=0, ovf=0. Takes effect immediately, including mid-pulse.
- Timer: down-counter, width $clog2(max(ON_CYCLES,GAP_CYCLES)+1).
- IDLE:
  - trig=1 goes to ON at the next edge: out=1, timer=ON_CYCLES-1. The trig is consumed directly and pending is unchanged.
  - Latency: out rises at the first posedge after the trig cycle.
- ON:
  - out=1 and timer decrements each cycle.
  - At timer==0, go to GAP: out=0, timer=GAP_CYCLES-1.
  - out is high for exactly ON_CYCLES cycles.
- GAP:
  - out=0 and timer decrements each cycle.
  - At timer==0, if pending>0 or trig=1, go to ON (out=1, timer=ON_CYCLES-1) and consume one event. Otherwise go to IDLE.
  - Consume priority: the queued event is taken first. If pending==0 and trig=1, the trig is consumed directly and pending stays 0.
- Queueing:
  - trig=1 in a cycle where it is not consumed increments pending.
  - Increment and decrement in the same cycle leave pending unchanged; this applies even at saturation, and nothing is dropped.
  - Increment with pending==2^PEND_W-1 and no decrement: the event is dropped and pending holds.
- busy = (state != IDLE), registered with the state.
- Back-to-back events produce out high for ON_CYCLES, low for GAP_CYCLES, repeating; there are never merged pulses.

Optional Feature:
Macro PULSE_STRETCH_OVF_EN.
- Defined: port ovf exists. It is set to 1 on the cycle after any dropped event and stays at 1 until clr.
- Undefined: no ovf port and no ovf logic. Drops are silent; all other behaviour is identical.

Decomposition:
- Package pulse_stretch_pkg holds:
  - state typedef enum {IDLE, ON, GAP}, 2 bits
  - helper function for timer width
- Natural sub-module: pulse_timer, a loadable down-counter with a zero flag. pulse_stretch instantiates one and owns the FSM and pending counter.

Test Plan:
Bench parameters: ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
1. Single trig in cycle 10 -> out=1 in cycles 11-14 and 0 from 15; busy=1 in cycles 11-16, 0 in 17; pending stays 0.
2. trig in cycles 10, 12, 13 -> three 4-cycle pulses starting at 11, 17 and 23, each separated by a 2-cycle gap; pending reads 1 then 2, then decrements to 0 at cycle 23.
3. trig held high for cycles 10-14 (5 events) -> pending saturates at 3 and one event is dropped; exactly 4 pulses total; ovf=1 from cycle 15 with macro, port absent without it.
4. Single trig at cycle 10, then a new trig in the last GAP cycle with pending=0 (cycle 16) -> out rises at cycle 17 with no IDLE cycle; pending stays 0 throughout.
5. Same as 4, but with pending=3 at gap end and trig=1 coincident -> pending stays 3, no drop, ovf unchanged.
6. clr asserted mid-ON (cycle 12 of scenario 1) -> out, busy and pending are 0 immediately without waiting for an edge; a trig at cycle 20 after release gives a normal pulse in cycles 21-24.
